// File: rtl/cpu_pkg.sv
// Shared types for the operand fetch sequencer.
//   fetch_state_t : sequencer states
//   OPC_*         : operand byte counts as carried on operand_count
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    DONE     = 2'd3
  } fetch_state_t;

  localparam logic [1:0] OPC_NONE = 2'd0;
  localparam logic [1:0] OPC_ONE  = 2'd1;
  localparam logic [1:0] OPC_TWO  = 2'd2;
  localparam logic [1:0] OPC_ILL  = 2'd3;

endpackage

// File: rtl/fetch_stall_timer.sv
// Stall watchdog for the operand fetch sequencer.
//   fclk    : clock
//   reset   : synchronous active-high reset
//   active  : sequencer is in a fetch state
//   ready   : bus RDY
//   expired : combinational, high in the stall cycle that brings the count
//             to TIMEOUT_CYCLES
module fetch_stall_timer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMO_W          = 8
) (
  input  logic fclk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  output logic expired
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  // Every state change out of a fetch state either passes through a
  // ready-high cycle or leaves the fetch states, so clearing on !active or
  // ready also covers the clear-on-state-change case.
  always_comb begin
    cnt_d = '0;
    if (active && !ready) cnt_d = cnt_q + TMO_W'(1);
  end

  always_ff @(posedge fclk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired = active && !ready && (cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/operand_fetch_sequencer.sv
// Operand fetch sequencer: after decode, loads operand bytes into the input
// data latch low byte first, honouring RDY and aborting on a long stall.
//   fclk, reset    : clock, synchronous active-high reset
//   start          : decoder pulse, accepted in IDLE or DONE
//   operand_count  : 0/1/2 operand bytes (3 = illegal), registered on accept
//   mem_ready      : bus byte valid this cycle
//   latch_clear    : clear input latch (accept or abort cycle)
//   latch_low_en   : load low byte
//   latch_high_en  : load high byte
//   pc_inc         : one per byte consumed
//   busy           : not IDLE
//   operands_done  : one-cycle pulse in DONE
//   bytes_fetched  : bytes loaded in current fetch, held until next accept
//   fetch_error    : one-cycle pulse on illegal count or stall timeout
module operand_fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMO_W          = 8
) (
  input  logic       fclk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] operand_count,
  input  logic       mem_ready,
  output logic       latch_clear,
  output logic       latch_low_en,
  output logic       latch_high_en,
  output logic       pc_inc,
  output logic       busy,
  output logic       operands_done,
  output logic [1:0] bytes_fetched,
  output logic       fetch_error
);

  fetch_state_t state_q, state_d;
  logic [1:0]   count_q, count_d;
  logic [1:0]   bytes_q, bytes_d;
  logic         accept, fetching, expired;

  assign accept   = start && (state_q == IDLE || state_q == DONE);
  assign fetching = (state_q == FETCH_LO) || (state_q == FETCH_HI);

  fetch_stall_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMO_W          (TMO_W)
  ) u_timer (
    .fclk    (fclk),
    .reset   (reset),
    .active  (fetching),
    .ready   (mem_ready),
    .expired (expired)
  );

  // State register plus registered count and byte counter
  always_ff @(posedge fclk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= OPC_NONE;
      bytes_q <= 2'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      bytes_q <= bytes_d;
    end
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    bytes_d = bytes_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          count_d = operand_count;
          bytes_d = 2'd0;
          case (operand_count)
            OPC_NONE:         state_d = DONE;
            OPC_ONE, OPC_TWO: state_d = FETCH_LO;
            default:          state_d = IDLE;
          endcase
        end
      end
      FETCH_LO: begin
        if (expired) state_d = IDLE;
        else if (mem_ready) begin
          bytes_d = 2'd1;
          state_d = (count_q == OPC_TWO) ? FETCH_HI : DONE;
        end
      end
      FETCH_HI: begin
        if (expired) state_d = IDLE;
        else if (mem_ready) begin
          bytes_d = 2'd2;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs; strobes are Mealy on mem_ready and suppressed on an abort cycle
  always_comb begin
    latch_clear   = accept || expired;
    latch_low_en  = (state_q == FETCH_LO) && mem_ready && !expired;
    latch_high_en = (state_q == FETCH_HI) && mem_ready && !expired;
    pc_inc        = latch_low_en || latch_high_en;
    busy          = (state_q != IDLE);
    operands_done = (state_q == DONE);
    fetch_error   = (accept && operand_count == OPC_ILL) || expired;
    bytes_fetched = bytes_q;
  end

endmodule
